// File: rtl/add64_pkg.sv
// rtl/add64_pkg.sv - shared widths and FSM state type for the two-pass 64-bit adder
package add64_pkg;
  localparam int WIDTH = 64;
  localparam int HALF  = 32;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} add64_state_t;
endpackage

// File: rtl/add64_seq.sv
// rtl/add64_seq.sv - 64-bit add/subtract over an external 32-bit adder in two passes
// Low half first, then high half with the carry chained through c_mid.
module add64_seq
  import add64_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic [HALF-1:0]  adder_a,
  output logic [HALF-1:0]  adder_b,
  output logic             adder_cin,
  input  logic [HALF-1:0]  adder_s,
  input  logic             adder_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  add64_state_t     state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c0_q, c0_d;
  logic             c_mid_q, c_mid_d;
  logic [HALF-1:0]  sum_lo_q, sum_lo_d;
  logic [HALF-1:0]  sum_hi_q, sum_hi_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             accept;

  assign in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  assign out_valid = valid_q;
  assign out_sum   = {sum_hi_q, sum_lo_q};
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

  // Adder inputs are held at zero outside the two compute passes.
  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (state_q == LO) begin
      adder_a   = a_q[HALF-1:0];
      adder_b   = b_q[HALF-1:0];
      adder_cin = c0_q;
    end else if (state_q == HI) begin
      adder_a   = a_q[WIDTH-1:HALF];
      adder_b   = b_q[WIDTH-1:HALF];
      adder_cin = c_mid_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c0_d     = c0_q;
    c_mid_d  = c_mid_q;
    sum_lo_d = sum_lo_q;
    sum_hi_d = sum_hi_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LO;
        end
      end
      LO: begin
        sum_lo_d = adder_s;
        c_mid_d  = adder_cout;
        state_d  = HI;
      end
      HI: begin
        sum_hi_d = adder_s;
        cout_d   = adder_cout;
        // b_q already holds the inverted operand for subtract, so one rule covers both.
        ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (adder_s[HALF-1] != a_q[WIDTH-1]);
        zero_d   = (sum_lo_q == '0) && (adder_s == '0);
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = accept ? LO : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      a_d  = in_a;
      b_d  = in_sub ? ~in_b : in_b;
      c0_d = in_sub;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c0_q     <= 1'b0;
      c_mid_q  <= 1'b0;
      sum_lo_q <= '0;
      sum_hi_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c0_q     <= c0_d;
      c_mid_q  <= c_mid_d;
      sum_lo_q <= sum_lo_d;
      sum_hi_q <= sum_hi_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_add64_seq.sv
// tb/tb_add64_seq.sv - randomized and directed bench for add64_seq with a behavioural 32-bit adder
module tb_add64_seq;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_sub;
  logic [31:0] adder_a;
  logic [31:0] adder_b;
  logic        adder_cin;
  logic [31:0] adder_s;
  logic        adder_cout;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  add64_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_s(adder_s), .adder_cout(adder_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  // Stand-in for the parent's sklansky_adder32.
  assign {adder_cout, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {32'd0, adder_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result packed as {zero, ovf, cout, sum}, from plain wide arithmetic.
  function automatic logic [66:0] ref_op(input logic [63:0] a, input logic [63:0] b, input logic sub);
    logic [64:0]        full;
    logic signed [65:0] w;
    logic               cout;
    logic               ovf;
    full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    cout = sub ? (a >= b) : full[64];
    w    = sub ? ($signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}))
               : ($signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}));
    ovf  = (w != {{2{w[63]}}, w[63:0]});
    return {(full[63:0] == 64'd0), ovf, cout, full[63:0]};
  endfunction

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_sub = ~sub;
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_a = 64'h1234; in_b = 64'h5678; in_sub = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hs in_ready=%0b out_valid=%0b required 0 0", in_ready, out_valid);
      end
      checks++;
      if (out_sum !== 64'd0 || out_cout !== 1'b0 || out_ovf !== 1'b0 || out_zero !== 1'b0) begin
        errors++;
        $display("FAIL reset_out sum=%h c=%0b v=%0b z=%0b required all 0", out_sum, out_cout, out_ovf, out_zero);
      end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [63:0] va [6];
    logic [63:0] vb [6];
    logic        vs [6];
    logic [66:0] exp;
    int          edges;
    va[0] = 64'h00000000_FFFFFFFF; vb[0] = 64'd1; vs[0] = 1'b0;
    va[1] = 64'hFFFFFFFF_FFFFFFFF; vb[1] = 64'd1; vs[1] = 1'b0;
    va[2] = 64'h7FFFFFFF_FFFFFFFF; vb[2] = 64'd1; vs[2] = 1'b0;
    va[3] = 64'd5;                 vb[3] = 64'd7; vs[3] = 1'b1;
    va[4] = 64'd7;                 vb[4] = 64'd7; vs[4] = 1'b1;
    va[5] = 64'h80000000_00000000; vb[5] = 64'd1; vs[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp = ref_op(va[i], vb[i], vs[i]);
      send(va[i], vb[i], vs[i]);
      wait_valid(edges);
      checks++;
      if (edges !== 3) begin
        errors++;
        $display("FAIL dir%0d_latency edges=%0d required 3", i, edges);
      end
      checks++;
      if (out_sum !== exp[63:0]) begin
        errors++;
        $display("FAIL dir%0d_sum got=%h required %h", i, out_sum, exp[63:0]);
      end
      checks++;
      if ({out_zero, out_ovf, out_cout} !== exp[66:64]) begin
        errors++;
        $display("FAIL dir%0d_flags zvc=%b required %b", i, {out_zero, out_ovf, out_cout}, exp[66:64]);
      end
      consume();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_drain out_valid=%0b required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    logic        s;
    logic [66:0] exp;
    int          edges;
    for (int i = 0; i < 12; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i < 3) b = ~a + 64'(i);
      s = 1'($urandom_range(0, 1));
      exp = ref_op(a, b, s);
      send(a, b, s);
      wait_valid(edges);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== exp[63:0]) begin
        errors++;
        $display("FAIL rand%0d_sum v=%0b got=%h required %h", i, out_valid, out_sum, exp[63:0]);
      end
      checks++;
      if ({out_zero, out_ovf, out_cout} !== exp[66:64]) begin
        errors++;
        $display("FAIL rand%0d_flags zvc=%b required %b", i, {out_zero, out_ovf, out_cout}, exp[66:64]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b;
    logic [66:0] exp;
    int          edges;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    exp = ref_op(a, b, 1'b0);
    send(a, b, 1'b0);
    wait_valid(edges);
    in_valid = 1'b1;
    repeat (5) begin
      in_a = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hs out_valid=%0b in_ready=%0b required 1 0", out_valid, in_ready);
      end
      checks++;
      if (out_sum !== exp[63:0] || {out_zero, out_ovf, out_cout} !== exp[66:64]) begin
        errors++;
        $display("FAIL bp_hold sum=%h zvc=%b required %h %b", out_sum, {out_zero, out_ovf, out_cout},
                 exp[63:0], exp[66:64]);
      end
    end
    in_valid = 1'b0;
    consume();
  endtask

  task automatic test_back_to_back();
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic        vs [4];
    logic [66:0] expq [$];
    logic [66:0] exp;
    logic        acc;
    int          idx, got, cyc, last;
    for (int i = 0; i < 4; i++) begin
      va[i] = {$urandom, $urandom};
      vb[i] = {$urandom, $urandom};
      vs[i] = 1'(i & 1);
    end
    idx = 0; got = 0; cyc = 0; last = -1;
    out_ready = 1'b1;
    in_a = va[0]; in_b = vb[0]; in_sub = vs[0]; in_valid = 1'b1;
    while (got < 4 && cyc < 60) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (adder_a !== 32'd0 || adder_b !== 32'd0 || adder_cin !== 1'b0) begin
          errors++;
          $display("FAIL b2b_adder_idle a=%h b=%h cin=%0b required 0", adder_a, adder_b, adder_cin);
        end
        exp = (expq.size() > 0) ? expq.pop_front() : 67'd0;
        checks++;
        if (out_sum !== exp[63:0] || {out_zero, out_ovf, out_cout} !== exp[66:64]) begin
          errors++;
          $display("FAIL b2b%0d_result sum=%h zvc=%b required %h %b", got, out_sum,
                   {out_zero, out_ovf, out_cout}, exp[63:0], exp[66:64]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 3) begin
            errors++;
            $display("FAIL b2b%0d_spacing cycles=%0d required 3", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      @(posedge clk);
      if (acc) begin
        expq.push_back(ref_op(va[idx], vb[idx], vs[idx]));
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (idx < 4) begin
        in_a = va[idx]; in_b = vb[idx]; in_sub = vs[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got !== 4) begin
      errors++;
      $display("FAIL b2b_count results=%0d required 4", got);
    end
  endtask

  task automatic test_reset_mid_hi();
    int edges;
    @(negedge clk);
    in_a = 64'hFFFF_0000_FFFF_0000; in_b = 64'h0000_FFFF_0000_FFFF; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midhi_reset out_valid=%0b in_ready=%0b required 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 64'd0) begin
      errors++;
      $display("FAIL midhi_hold out_valid=%0b sum=%h required 0 0", out_valid, out_sum);
    end
    rst_n = 1'b1;
    send(64'd2, 64'd3, 1'b0);
    wait_valid(edges);
    checks++;
    if (edges !== 3 || out_sum !== 64'd5 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL midhi_after edges=%0d sum=%h z=%0b required 3 5 0", edges, out_sum, out_zero);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_hi();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
